ysyx_22040237_regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the pipelined core. It provides a configurable number of read ports, two write-back ports, optional write-to-read bypass, and a per-register busy scoreboard. Issue logic uses the scoreboard for RAW hazard detection. It sits between decode/issue (reads, busy set) and write-back (writes, busy clear), and also exposes a debug read port for the difftest harness.

---
 rtl/ysyx_22040237_regfile_mp.sv | 137 +++++++++++++
 tb/tb_ysyx_22040237_regfile_mp.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040237_regfile_mp.sv
// Multi-port integer register file: NRD combinational read ports, two write-back
// ports, optional write-to-read forwarding, per-register busy scoreboard and a debug port.
module ysyx_22040237_regfile_mp #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr0_en,
  input  logic [AW-1:0]       wr0_addr,
  input  logic [XLEN-1:0]     wr0_data,
  input  logic                wr1_en,
  input  logic [AW-1:0]       wr1_addr,
  input  logic [XLEN-1:0]     wr1_data,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  localparam logic [AW:0] NREG_L = (AW+1)'(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            wr0_ok;
  logic            wr1_ok;
  logic            iss_ok;

  // Register 0 and indices beyond NREG are never written, issued or read.
  function automatic logic valid_idx(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NREG_L);
  endfunction

  function automatic logic [XLEN-1:0] stored(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = '0;
    for (int r = 0; r < NREG; r++) begin
      if (a == AW'(r)) v = regs_q[r];
    end
    return v;
  endfunction

  function automatic logic busy_of(input logic [AW-1:0] a);
    logic b;
    b = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      if (a == AW'(r)) b = busy_q[r];
    end
    return b;
  endfunction

  always_comb begin
    wr0_ok = wr0_en && valid_idx(wr0_addr);
    wr1_ok = wr1_en && valid_idx(wr1_addr);
    iss_ok = iss_en && valid_idx(iss_addr);
  end

  // Next-state for storage and scoreboard; wr1 wins a same-register write collision.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      regs_d[r] = regs_q[r];
      busy_d[r] = busy_q[r];
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      if (wr1_ok && wr1_addr == AW'(r)) begin
        regs_d[r] = wr1_data;
      end else if (wr0_ok && wr0_addr == AW'(r)) begin
        regs_d[r] = wr0_data;
      end

      // A new producer outranks a same-cycle write-back; flush outranks both.
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (iss_ok && iss_addr == AW'(r)) begin
        busy_d[r] = 1'b1;
      end else if ((wr1_ok && wr1_addr == AW'(r)) || (wr0_ok && wr0_addr == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin : rd_mux
    logic [AW-1:0]   a;
    logic [XLEN-1:0] data;
    logic            busy;
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      a    = rd_addr[k*AW +: AW];
      data = '0;
      busy = 1'b0;
      if (rd_en[k] && valid_idx(a)) begin
        data = stored(a);
        busy = busy_of(a);
        // Forwarded data is already the producer's result, so it is no longer pending.
        if (BYPASS != 0) begin
          if (wr1_ok && wr1_addr == a) begin
            data = wr1_data;
            busy = 1'b0;
          end else if (wr0_ok && wr0_addr == a) begin
            data = wr0_data;
            busy = 1'b0;
          end
        end
      end
      rd_data[k*XLEN +: XLEN] = data;
      rd_busy[k]              = busy;
    end
  end

  always_comb begin
    dbg_data = stored(dbg_addr);
  end

endmodule

// File: tb/tb_ysyx_22040237_regfile_mp.sv
// Directed bench for ysyx_22040237_regfile_mp: default, no-bypass and small
// (NRD=3, NREG=16, XLEN=32) instances driven by one linear stimulus sequence.
module tb_ysyx_22040237_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;

  // Shared stimulus for the default (a) and BYPASS=0 (b) instances.
  logic        wr0_en, wr1_en, iss_en, flush;
  logic [4:0]  wr0_addr, wr1_addr, iss_addr, dbg_addr;
  logic [63:0] wr0_data, wr1_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [127:0] a_rd_data, b_rd_data;
  logic [1:0]  a_rd_busy, b_rd_busy;
  logic [63:0] a_dbg, b_dbg;

  // Stimulus for the small instance (c).
  logic        c_wr0_en, c_wr1_en, c_iss_en, c_flush;
  logic [4:0]  c_wr0_addr, c_wr1_addr, c_iss_addr, c_dbg_addr;
  logic [31:0] c_wr0_data, c_wr1_data;
  logic [2:0]  c_rd_en;
  logic [14:0] c_rd_addr;
  logic [95:0] c_rd_data;
  logic [2:0]  c_rd_busy;
  logic [31:0] c_dbg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_22040237_regfile_mp dut_a (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .dbg_addr(dbg_addr), .dbg_data(a_dbg)
  );

  ysyx_22040237_regfile_mp #(.BYPASS(0)) dut_b (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .dbg_addr(dbg_addr), .dbg_data(b_dbg)
  );

  ysyx_22040237_regfile_mp #(.XLEN(32), .NREG(16), .AW(5), .NRD(3), .BYPASS(1)) dut_c (
    .clk(clk), .rst(rst),
    .wr0_en(c_wr0_en), .wr0_addr(c_wr0_addr), .wr0_data(c_wr0_data),
    .wr1_en(c_wr1_en), .wr1_addr(c_wr1_addr), .wr1_data(c_wr1_data),
    .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
    .iss_en(c_iss_en), .iss_addr(c_iss_addr), .flush(c_flush),
    .dbg_addr(c_dbg_addr), .dbg_data(c_dbg)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    wr0_en = 0; wr1_en = 0; iss_en = 0; flush = 0;
    c_wr0_en = 0; c_wr1_en = 0; c_iss_en = 0; c_flush = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wr0_addr = 0; wr1_addr = 0; iss_addr = 0; dbg_addr = 0;
    wr0_data = 0; wr1_data = 0; rd_en = 0; rd_addr = 0;
    c_wr0_addr = 0; c_wr1_addr = 0; c_iss_addr = 0; c_dbg_addr = 0;
    c_wr0_data = 0; c_wr1_data = 0; c_rd_en = 0; c_rd_addr = 0;
    tick();
    rst = 1'b0;
    settle();
    chk("init_dbg", a_dbg, 64'h0);
    chk("init_rd", a_rd_data[63:0], 64'h0);

    // 1. Preload 1..31 with busy set (issue beats same-cycle write), then reset.
    for (int r = 1; r < 32; r++) begin
      wr0_en = 1; wr0_addr = 5'(r); wr0_data = 64'h1000_0000_0000_0000 + 64'(r);
      iss_en = 1; iss_addr = 5'(r);
      tick();
    end
    idle();
    dbg_addr = 31; rd_en = 2'b01; rd_addr[4:0] = 5;
    settle();
    chk("preload_dbg31", a_dbg, 64'h1000_0000_0000_001F);
    chk("preload_busy5", {63'h0, a_rd_busy[0]}, 64'h1);
    rst = 1; wr0_en = 1; wr0_addr = 6; wr0_data = 64'hFFFF; iss_en = 1; iss_addr = 7;
    tick();
    rst = 0; idle();
    rd_en = 2'b11;
    for (int r = 0; r < 32; r++) begin
      dbg_addr = 5'(r); rd_addr = {5'(r), 5'(r)};
      settle();
      chk($sformatf("rst_dbg_%0d", r), a_dbg, 64'h0);
      chk($sformatf("rst_rd_%0d", r), a_rd_data[127:64], 64'h0);
      chk($sformatf("rst_busy_%0d", r), {62'h0, a_rd_busy}, 64'h0);
    end

    // 2. Same-cycle forwarding vs stored-only read.
    wr0_en = 1; wr0_addr = 5; wr0_data = 64'hDEAD_BEEF_0000_0001;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    settle();
    chk("byp_same_cycle", a_rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
    chk("nobyp_same_cycle", b_rd_data[63:0], 64'h0);
    tick();
    idle();
    settle();
    chk("byp_next", a_rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
    chk("nobyp_next", b_rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
    rd_en = 2'b10; rd_addr = {5'd5, 5'd5};
    settle();
    chk("rd_en_off_data", a_rd_data[63:0], 64'h0);

    // 3. Register 0 writes discarded; wr1 wins a collision.
    wr0_en = 1; wr0_addr = 0; wr0_data = 64'h1234;
    rd_en = 2'b10; rd_addr = {5'd0, 5'd0};
    settle();
    chk("r0_byp", a_rd_data[127:64], 64'h0);
    tick();
    idle(); dbg_addr = 0; rd_en = 2'b11;
    settle();
    chk("r0_dbg", a_dbg, 64'h0);
    chk("r0_rd_nobyp", b_rd_data[127:64], 64'h0);
    wr0_en = 1; wr0_addr = 7; wr0_data = 64'hAA;
    wr1_en = 1; wr1_addr = 7; wr1_data = 64'hBB;
    rd_addr = {5'd0, 5'd7};
    settle();
    chk("prio_byp", a_rd_data[63:0], 64'hBB);
    tick();
    idle(); dbg_addr = 7;
    settle();
    chk("prio_dbg", a_dbg, 64'hBB);
    chk("prio_nobyp", b_rd_data[63:0], 64'hBB);

    // 4. Scoreboard set, clear by write-back, issue beating write-back.
    iss_en = 1; iss_addr = 9; rd_en = 2'b01; rd_addr = {5'd9, 5'd9};
    settle();
    chk("busy_not_yet", {63'h0, a_rd_busy[0]}, 64'h0);
    tick();
    idle();
    settle();
    chk("busy_set_a", {62'h0, a_rd_busy}, 64'h1);
    chk("busy_set_b", {62'h0, b_rd_busy}, 64'h1);
    wr1_en = 1; wr1_addr = 9; wr1_data = 64'h55;
    settle();
    chk("wb_busy_byp", {63'h0, a_rd_busy[0]}, 64'h0);
    chk("wb_data_byp", a_rd_data[63:0], 64'h55);
    chk("wb_busy_nobyp", {63'h0, b_rd_busy[0]}, 64'h1);
    chk("wb_data_nobyp", b_rd_data[63:0], 64'h0);
    tick();
    idle();
    settle();
    chk("wb_cleared", {63'h0, b_rd_busy[0]}, 64'h0);
    chk("wb_stored", b_rd_data[63:0], 64'h55);
    iss_en = 1; iss_addr = 9; wr0_en = 1; wr0_addr = 9; wr0_data = 64'h66;
    tick();
    idle(); dbg_addr = 9;
    settle();
    chk("iss_over_wb_busy", {63'h0, a_rd_busy[0]}, 64'h1);
    chk("iss_over_wb_dbg", a_dbg, 64'h66);
    iss_en = 1; iss_addr = 0;
    tick();
    idle(); rd_addr = {5'd0, 5'd0};
    settle();
    chk("r0_never_busy", {63'h0, a_rd_busy[0]}, 64'h0);

    // 5. Flush clears everything and beats a same-cycle issue.
    iss_en = 1; iss_addr = 3; tick();
    iss_addr = 4; tick();
    iss_addr = 31; tick();
    idle(); rd_en = 2'b11; rd_addr = {5'd31, 5'd3};
    settle();
    chk("pre_flush_busy", {62'h0, a_rd_busy}, 64'h3);
    flush = 1; iss_en = 1; iss_addr = 3;
    tick();
    idle();
    settle();
    chk("flush_3_31", {62'h0, a_rd_busy}, 64'h0);
    rd_addr = {5'd9, 5'd4};
    settle();
    chk("flush_4_9", {62'h0, a_rd_busy}, 64'h0);

    // 6. Small instance: out-of-range index, independent ports.
    c_wr0_en = 1; c_wr0_addr = 1;  c_wr0_data = 32'h1111_1111;
    c_wr1_en = 1; c_wr1_addr = 2;  c_wr1_data = 32'h2222_2222;
    tick();
    idle();
    c_wr0_en = 1; c_wr0_addr = 15; c_wr0_data = 32'hFFFF_000F;
    tick();
    idle();
    c_wr0_en = 1; c_wr0_addr = 20; c_wr0_data = 32'h0BAD;
    c_iss_en = 1; c_iss_addr = 20;
    c_rd_en = 3'b111; c_rd_addr = {5'd20, 5'd20, 5'd20};
    settle();
    chk("c_oor_byp", {32'h0, c_rd_data[31:0]}, 64'h0);
    tick();
    idle();
    c_rd_addr = {5'd15, 5'd2, 5'd1};
    settle();
    chk("c_port0", {32'h0, c_rd_data[31:0]}, 64'h1111_1111);
    chk("c_port1", {32'h0, c_rd_data[63:32]}, 64'h2222_2222);
    chk("c_port2", {32'h0, c_rd_data[95:64]}, 64'hFFFF_000F);
    c_rd_addr = {5'd0, 5'd15, 5'd20};
    c_dbg_addr = 20;
    settle();
    chk("c_oor_rd", {32'h0, c_rd_data[31:0]}, 64'h0);
    chk("c_oor_busy", {61'h0, c_rd_busy}, 64'h0);
    chk("c_port1_15", {32'h0, c_rd_data[63:32]}, 64'hFFFF_000F);
    chk("c_port2_r0", {32'h0, c_rd_data[95:64]}, 64'h0);
    chk("c_oor_dbg", {32'h0, c_dbg}, 64'h0);
    c_rd_en = 3'b101;
    settle();
    chk("c_en_mask", {32'h0, c_rd_data[63:32]}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
